// File: rtl/xor_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : xor_addsub_seq
//  Description : Multi-cycle conditional-invert / add / subtract unit.
//                Operands are pre-conditioned on accept (XOR invert and carry
//                seed chosen by op). One CHUNK-bit adder slice then
//                processes the operands LSB chunk first. The carry is held in
//                a register between cycles. Valid/ready handshake on the
//                input and output sides.
//  Ports       : clk, reset (sync, active-high)
//                in_valid / in_ready, op[1:0], a, b         - request side
//                out_valid / out_ready, result, carry_out,
//                overflow, zero                              - response side
//                op: 00 ADD a+b, 01 SUB a-b, 10 INV ~a, 11 NEG -a
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_NCHUNK = WIDTH / CHUNK;
    localparam int c_IDXW   = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_IDXW-1:0] c_IDX_LAST = c_IDXW'(c_NCHUNK - 1);
    localparam logic [c_IDXW-1:0] c_IDX_ONE  = c_IDXW'(1);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_INV = 2'b10;
    localparam logic [1:0] c_OP_NEG = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic              r_carry;
    logic [c_IDXW-1:0] r_idx;
    logic              r_is_inv;
    logic [WIDTH-1:0]  r_result;
    logic              r_carry_out;
    logic              r_overflow;
    logic              r_zero;

    logic [CHUNK-1:0]  w_xc;
    logic [CHUNK-1:0]  w_yc;
    logic [CHUNK:0]    w_sum_full;
    logic [CHUNK-1:0]  w_sum;
    logic              w_cout;
    logic              w_cmsb_in;
    logic [WIDTH-1:0]  w_next_result;
    logic              w_last;

    // Handshake flags come straight from the state register.
    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

    assign w_last = (r_idx == c_IDX_LAST);

    always_comb begin
        w_xc       = r_x[r_idx*CHUNK +: CHUNK];
        w_yc       = r_y[r_idx*CHUNK +: CHUNK];
        w_sum_full = {1'b0, w_xc} + {1'b0, w_yc} + {{CHUNK{1'b0}}, r_carry};
        w_sum      = w_sum_full[CHUNK-1:0];
        w_cout     = w_sum_full[CHUNK];
        // Carry into the MSB recovered from the MSB full-adder equation
        // s = x ^ y ^ cin; only meaningful on the last chunk.
        w_cmsb_in  = w_sum[CHUNK-1] ^ w_xc[CHUNK-1] ^ w_yc[CHUNK-1];
        w_next_result = r_result;
        w_next_result[r_idx*CHUNK +: CHUNK] = w_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_is_inv    <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        // op[1] selects the inverted-A forms (INV/NEG).
                        r_x      <= op[1] ? ~a : a;
                        r_y      <= (op == c_OP_ADD) ? b :
                                    (op == c_OP_SUB) ? ~b : '0;
                        r_carry  <= (op == c_OP_SUB) || (op == c_OP_NEG);
                        r_is_inv <= (op == c_OP_INV);
                        r_idx    <= '0;
                        r_state  <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_result <= w_next_result;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + c_IDX_ONE;
                    if (w_last) begin
                        r_carry_out <= w_cout;
                        r_overflow  <= r_is_inv ? 1'b0 : (w_cmsb_in ^ w_cout);
                        r_zero      <= (w_next_result == '0);
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
